// File: rtl/complex_vec_mac_pkg.sv
// Shared types and width helpers for the streaming complex multiply/accumulate engine.
package complex_vec_mac_pkg;

  typedef enum logic {
    MODE_ELEM = 1'b0,
    MODE_DOT  = 1'b1
  } mode_e;

  function automatic int unsigned calc_prod_w(int unsigned width);
    return 2 * width + 1;
  endfunction

  // Headroom of clog2(size) bits lets a full dot product accumulate without overflow.
  function automatic int unsigned calc_acc_w(int unsigned width, int unsigned size);
    return calc_prod_w(width) + $clog2(size);
  endfunction

endpackage

// File: rtl/complex_vec_mac_cmul_lane.sv
// One full-precision complex multiplier lane with optional conjugation of b and an
// enabled stage-1 product register.
module cmul_lane #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PROD_W = 2 * WIDTH + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              conj_i,
  input  logic [WIDTH-1:0]  a_re_i,
  input  logic [WIDTH-1:0]  a_im_i,
  input  logic [WIDTH-1:0]  b_re_i,
  input  logic [WIDTH-1:0]  b_im_i,
  output logic [PROD_W-1:0] re_o,
  output logic [PROD_W-1:0] im_o
);

  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PROD_W-1:0]  x_rr, x_ii, x_ri, x_ir;
  logic signed [PROD_W-1:0]  re_d, im_d;
  logic        [PROD_W-1:0]  re_q, im_q;

  assign p_rr = $signed(a_re_i) * $signed(b_re_i);
  assign p_ii = $signed(a_im_i) * $signed(b_im_i);
  assign p_ri = $signed(a_re_i) * $signed(b_im_i);
  assign p_ir = $signed(a_im_i) * $signed(b_re_i);

  // One extra bit so (-2^(W-1))^2 + (-2^(W-1))^2 cannot wrap.
  assign x_rr = PROD_W'(p_rr);
  assign x_ii = PROD_W'(p_ii);
  assign x_ri = PROD_W'(p_ri);
  assign x_ir = PROD_W'(p_ir);

  always_comb begin
    if (conj_i) begin
      re_d = x_rr + x_ii;
      im_d = x_ir - x_ri;
    end else begin
      re_d = x_rr - x_ii;
      im_d = x_ri + x_ir;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_q <= '0;
      im_q <= '0;
    end else if (en_i) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/complex_vec_mac.sv
// Streaming complex vector multiply/accumulate: per-element products or a complex dot
// product over SIZE elements delivered as SIZE/LANES beats, two-stage pipeline.
module complex_vec_mac
  import complex_vec_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SIZE  = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic                                          mode_i,
  input  logic                                          conj_i,
  input  logic                                          in_valid_i,
  output logic                                          in_ready_o,
  input  logic [4*LANES*WIDTH-1:0]                      operands_i,
  output logic [2*LANES*calc_acc_w(WIDTH, SIZE)-1:0]    result_o,
  output logic                                          out_last_o,
  output logic                                          out_valid_o,
  input  logic                                          out_ready_i,
  output logic                                          busy_o
);

  localparam int unsigned PROD_W = calc_prod_w(WIDTH);
  localparam int unsigned ACC_W  = calc_acc_w(WIDTH, SIZE);
  localparam int unsigned NBEATS = SIZE / LANES;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned RES_W  = 2 * LANES * ACC_W;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  mode_e            mode_q, mode_d;
  logic             conj_q, conj_d;

  logic  stall, accept, first_beat, last_beat, conj_eff;
  mode_e mode_eff;

  logic  s1_valid_q, s1_last_q;
  mode_e s1_mode_q;

  logic [PROD_W-1:0] lane_re [LANES];
  logic [PROD_W-1:0] lane_im [LANES];
  logic [ACC_W-1:0]  sum_re, sum_im;

  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;

  assign stall      = out_valid_q && !out_ready_i;
  assign in_ready_o = !stall && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign first_beat = (state_q == StIdle);
  assign last_beat  = (count_q == CNT_W'(NBEATS - 1));
  assign mode_eff   = first_beat ? mode_e'(mode_i) : mode_q;
  assign conj_eff   = first_beat ? conj_i : conj_q;

  // Beat counter FSM
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    conj_d  = conj_q;
    if (flush_i) begin
      state_d = StIdle;
      count_d = '0;
    end else if (accept) begin
      mode_d = mode_eff;
      conj_d = conj_eff;
      if (last_beat) begin
        state_d = StIdle;
        count_d = '0;
      end else begin
        state_d = StActive;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      count_q <= '0;
      mode_q  <= MODE_ELEM;
      conj_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      conj_q  <= conj_d;
    end
  end

  // Stage 1: lane products; only loaded on an accepted beat, which implies no stall.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cmul_lane #(
      .WIDTH (WIDTH),
      .PROD_W(PROD_W)
    ) u_lane (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (accept),
      .conj_i(conj_eff),
      .a_re_i(operands_i[(4*k)*WIDTH +: WIDTH]),
      .a_im_i(operands_i[(4*k+1)*WIDTH +: WIDTH]),
      .b_re_i(operands_i[(4*k+2)*WIDTH +: WIDTH]),
      .b_im_i(operands_i[(4*k+3)*WIDTH +: WIDTH]),
      .re_o  (lane_re[k]),
      .im_o  (lane_im[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= MODE_ELEM;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      s1_last_q  <= last_beat;
      s1_mode_q  <= mode_eff;
    end
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_re = sum_re + ACC_W'($signed(lane_re[k]));
      sum_im = sum_im + ACC_W'($signed(lane_im[k]));
    end
  end

  // Stage 2: accumulate and output register
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    result_d    = result_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      acc_re_d    = '0;
      acc_im_d    = '0;
    end else if (!stall) begin
      out_valid_d = 1'b0;
      if (s1_valid_q) begin
        if (s1_mode_q == MODE_ELEM) begin
          out_valid_d = 1'b1;
          out_last_d  = s1_last_q;
          for (int k = 0; k < LANES; k++) begin
            result_d[(2*k)*ACC_W +: ACC_W]   = ACC_W'($signed(lane_re[k]));
            result_d[(2*k+1)*ACC_W +: ACC_W] = ACC_W'($signed(lane_im[k]));
          end
        end else if (s1_last_q) begin
          out_valid_d              = 1'b1;
          out_last_d               = 1'b1;
          result_d                 = '0;
          result_d[0 +: ACC_W]     = acc_re_q + sum_re;
          result_d[ACC_W +: ACC_W] = acc_im_q + sum_im;
          acc_re_d                 = '0;
          acc_im_d                 = '0;
        end else begin
          acc_re_d = acc_re_q + sum_re;
          acc_im_d = acc_im_q + sum_im;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      result_q    <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      result_q    <= result_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign result_o    = result_q;
  assign busy_o      = (state_q != StIdle) || s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_complex_vec_mac.sv
// Randomised and directed bench for complex_vec_mac with a queue-based reference model.
module tb_complex_vec_mac;

  localparam int W     = 16;
  localparam int SZ    = 8;
  localparam int LN    = 4;
  localparam int NB    = SZ / LN;
  localparam int ACC_W = 2 * W + 1 + $clog2(SZ);
  localparam int OPW   = 4 * LN * W;
  localparam int RW    = 2 * LN * ACC_W;

  logic           clk, rst_ni, flush_i, mode_i, conj_i, in_valid_i, in_ready_o;
  logic [OPW-1:0] operands_i;
  logic [RW-1:0]  result_o;
  logic           out_last_o, out_valid_o, out_ready_i, busy_o;

  complex_vec_mac #(
    .WIDTH(W),
    .SIZE (SZ),
    .LANES(LN)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .mode_i     (mode_i),
    .conj_i     (conj_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .operands_i (operands_i),
    .result_o   (result_o),
    .out_last_o (out_last_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] res;
    logic          last;
    int            rdy;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_chk = 0, n_pass = 0, cyc = 0, out_cnt = 0, m_cnt = 0;
  bit            m_mode = 0, m_conj = 0, rand_rdy = 0, prev_stall = 0;
  longint        m_acc_re = 0, m_acc_im = 0;
  logic [RW-1:0] prev_res;
  logic          prev_last;

  task automatic chk(input bit ok, input string name, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic longint comp(input logic [OPW-1:0] v, input int i);
    return $signed(v[i*W +: W]);
  endfunction

  function automatic longint lane_of(input logic [RW-1:0] r, input int i);
    return $signed(r[i*ACC_W +: ACC_W]);
  endfunction

  function automatic logic [OPW-1:0] put(input logic [OPW-1:0] v, input int k, input int ar,
                                         input int ai, input int br, input int bi);
    v[(4*k)*W +: W]   = W'(ar);
    v[(4*k+1)*W +: W] = W'(ai);
    v[(4*k+2)*W +: W] = W'(br);
    v[(4*k+3)*W +: W] = W'(bi);
    return v;
  endfunction

  function automatic logic [OPW-1:0] all_lanes(input int ar, input int ai, input int br,
                                               input int bi);
    logic [OPW-1:0] v = '0;
    for (int k = 0; k < LN; k++) v = put(v, k, ar, ai, br, bi);
    return v;
  endfunction

  function automatic logic [OPW-1:0] rnd_ops();
    logic [OPW-1:0] v;
    for (int i = 0; i < 4 * LN; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  // Reference model: complex arithmetic on the accepted beat, expected beats queued.
  task automatic model_accept(input logic [OPW-1:0] ops, input bit md, input bit cj);
    longint ar, ai, br, bi, re, im, sre, sim;
    exp_t   e;
    bit     last;
    if (m_cnt == 0) begin
      m_mode = md;
      m_conj = cj;
    end
    last  = (m_cnt == NB - 1);
    sre   = 0;
    sim   = 0;
    e.res = '0;
    e.rdy = cyc + 2;
    e.last = last;
    for (int k = 0; k < LN; k++) begin
      ar = comp(ops, 4*k);
      ai = comp(ops, 4*k+1);
      br = comp(ops, 4*k+2);
      bi = comp(ops, 4*k+3);
      if (m_conj) begin
        re = ar * br + ai * bi;
        im = ai * br - ar * bi;
      end else begin
        re = ar * br - ai * bi;
        im = ar * bi + ai * br;
      end
      sre += re;
      sim += im;
      e.res[(2*k)*ACC_W +: ACC_W]   = ACC_W'(re);
      e.res[(2*k+1)*ACC_W +: ACC_W] = ACC_W'(im);
    end
    if (!m_mode) begin
      exp_q.push_back(e);
    end else begin
      m_acc_re += sre;
      m_acc_im += sim;
      if (last) begin
        e.res = '0;
        e.res[0 +: ACC_W]     = ACC_W'(m_acc_re);
        e.res[ACC_W +: ACC_W] = ACC_W'(m_acc_im);
        e.last = 1'b1;
        exp_q.push_back(e);
        m_acc_re = 0;
        m_acc_im = 0;
      end
    end
    m_cnt = (m_cnt + 1) % NB;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt    = 0;
    m_acc_re = 0;
    m_acc_im = 0;
  endtask

  // Compare process: samples on the falling edge, inputs change just after the rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      prev_stall = 0;
    end else begin
      cyc++;
      if (prev_stall)
        chk(out_valid_o && result_o == prev_res && out_last_o == prev_last, "stall_hold",
            $sformatf("valid=%0b last=%0b res=%h, required held res=%h last=%0b",
                      out_valid_o, out_last_o, result_o, prev_res, prev_last));
      chk(in_ready_o == (!(out_valid_o && !out_ready_i) && !flush_i), "in_ready",
          $sformatf("in_ready=%0b with out_valid=%0b out_ready=%0b flush=%0b",
                    in_ready_o, out_valid_o, out_ready_i, flush_i));
      if (out_valid_o && out_ready_i) begin
        out_cnt++;
        chk(exp_q.size() > 0, "out_expected", $sformatf("unexpected output res=%h", result_o));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk(result_o == mon_e.res && out_last_o == mon_e.last && cyc >= mon_e.rdy, "out_beat",
              $sformatf("got res=%h last=%0b cyc=%0d, required res=%h last=%0b cyc>=%0d",
                        result_o, out_last_o, cyc, mon_e.res, mon_e.last, mon_e.rdy));
        end
      end
      prev_stall = out_valid_o && !out_ready_i && !flush_i;
      prev_res   = result_o;
      prev_last  = out_last_o;
      if (flush_i) model_clear();
      else if (in_valid_i && in_ready_o) model_accept(operands_i, mode_i, conj_i);
    end
  end

  initial forever begin
    @(posedge clk);
    if (rand_rdy) begin
      #1;
      out_ready_i = ($urandom % 10) < 7;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [OPW-1:0] ops, input bit md, input bit cj);
    bit done = 0;
    operands_i = ops;
    mode_i     = md;
    conj_i     = cj;
    in_valid_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready_o) done = 1;
    end
    chk(done, "accept", "beat not accepted within 200 cycles, required acceptance");
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  initial begin
    logic [OPW-1:0] ops;
    int             n0;
    bit             zero_ok;
    rst_ni = 0; flush_i = 0; mode_i = 0; conj_i = 0; in_valid_i = 0;
    operands_i = '0; out_ready_i = 1;
    #22 rst_ni = 1;
    idle(1);
    chk(!out_valid_o && result_o == '0 && !out_last_o && !busy_o && in_ready_o, "reset_state",
        $sformatf("valid=%0b res=%h last=%0b busy=%0b ready=%0b, required 0/0/0/0/1",
                  out_valid_o, result_o, out_last_o, busy_o, in_ready_o));

    // ELEM, no conj: lane 0 (3+4j)(1+2j) = -5+10j; mode/conj ignored on beat 1
    ops = put('0, 0, 3, 4, 1, 2);
    send_beat(ops, 0, 0);
    send_beat('0, 1, 1);
    chk(out_valid_o && lane_of(result_o, 0) == -5 && lane_of(result_o, 1) == 10 && !out_last_o,
        "elem_lane0", $sformatf("valid=%0b re=%0d im=%0d last=%0b, required 1 -5 10 0",
        out_valid_o, lane_of(result_o, 0), lane_of(result_o, 1), out_last_o));
    idle(1);
    chk(out_valid_o && out_last_o && lane_of(result_o, 0) == 0, "elem_last",
        $sformatf("valid=%0b last=%0b re=%0d, required 1 1 0",
                  out_valid_o, out_last_o, lane_of(result_o, 0)));
    idle(3);

    // DOT with conj: eight (1+j)*conj(1+j) = 2 each -> 16+0j
    ops = all_lanes(1, 1, 1, 1);
    send_beat(ops, 1, 1);
    send_beat(ops, 0, 0);
    chk(!out_valid_o, "dot_no_early", $sformatf("valid=%0b, required 0", out_valid_o));
    idle(1);
    zero_ok = 1;
    for (int i = 2; i < 2 * LN; i++) if (lane_of(result_o, i) != 0) zero_ok = 0;
    chk(out_valid_o && out_last_o && lane_of(result_o, 0) == 16 && lane_of(result_o, 1) == 0 &&
        zero_ok, "dot_conj", $sformatf("valid=%0b last=%0b re=%0d im=%0d res=%h, required 16+0j",
        out_valid_o, out_last_o, lane_of(result_o, 0), lane_of(result_o, 1), result_o));
    idle(3);

    // Extremes: (-32768-32768j)^2 = 0 + 2^31 j
    ops = all_lanes(-32768, -32768, -32768, -32768);
    send_beat(ops, 0, 0);
    send_beat(ops, 0, 0);
    chk(out_valid_o && lane_of(result_o, 0) == 0 && lane_of(result_o, 1) == 64'sd2147483648 &&
        lane_of(result_o, 7) == 64'sd2147483648, "elem_extreme",
        $sformatf("re=%0d im=%0d im3=%0d, required 0 2147483648 2147483648",
                  lane_of(result_o, 0), lane_of(result_o, 1), lane_of(result_o, 7)));
    idle(3);

    // Back-to-back ELEM vectors with a 5-cycle output stall mid-stream
    n0 = out_cnt;
    fork
      begin
        for (int b = 0; b < 2 * NB; b++) send_beat(rnd_ops(), 0, $urandom % 2);
      end
      begin
        idle(2);
        out_ready_i = 0;
        idle(5);
        out_ready_i = 1;
      end
    join
    idle(6);
    chk(out_cnt - n0 == 2 * NB && exp_q.size() == 0, "stall_count",
        $sformatf("outputs=%0d pending=%0d, required %0d and 0", out_cnt - n0, exp_q.size(),
                  2 * NB));

    // Flush after DOT beat 0, then a clean DOT vector of (2+0j)(1+0j)
    send_beat(rnd_ops(), 1, 0);
    flush_i = 1;
    idle(1);
    flush_i = 0;
    n0 = out_cnt;
    idle(3);
    chk(out_cnt == n0 && !out_valid_o && !busy_o, "flush_clear",
        $sformatf("outputs=%0d valid=%0b busy=%0b, required 0 0 0", out_cnt - n0, out_valid_o,
                  busy_o));
    ops = all_lanes(2, 0, 1, 0);
    send_beat(ops, 1, 0);
    send_beat(ops, 1, 0);
    idle(1);
    chk(out_valid_o && out_last_o && lane_of(result_o, 0) == 16 && lane_of(result_o, 1) == 0,
        "dot_after_flush", $sformatf("valid=%0b last=%0b re=%0d im=%0d, required 16+0j",
        out_valid_o, out_last_o, lane_of(result_o, 0), lane_of(result_o, 1)));
    idle(3);

    // Asynchronous reset mid-vector with a stalled output
    out_ready_i = 0;
    send_beat(rnd_ops(), 0, 0);
    idle(1);
    chk(out_valid_o && busy_o, "pre_reset",
        $sformatf("valid=%0b busy=%0b, required 1 1", out_valid_o, busy_o));
    #2 rst_ni = 0;
    #1;
    chk(!out_valid_o && !busy_o && result_o == '0, "async_reset",
        $sformatf("valid=%0b busy=%0b res=%h, required 0 0 0", out_valid_o, busy_o, result_o));
    idle(1);
    rst_ni = 1;
    model_clear();
    out_ready_i = 1;
    send_beat(ops, 1, 0);
    send_beat(ops, 0, 0);
    idle(1);
    chk(out_valid_o && out_last_o && lane_of(result_o, 0) == 16, "reset_resample",
        $sformatf("valid=%0b last=%0b re=%0d, required 1 1 16", out_valid_o, out_last_o,
                  lane_of(result_o, 0)));
    idle(3);

    // Randomised traffic: random modes, gaps, backpressure and occasional flushes
    rand_rdy = 1;
    for (int v = 0; v < 40; v++) begin
      bit md, cj;
      md = 1'($urandom % 2);
      cj = 1'($urandom % 2);
      for (int b = 0; b < NB; b++) begin
        int gap;
        gap = $urandom % 3;
        if (gap > 0) idle(gap);
        if (b == 0) send_beat(rnd_ops(), md, cj);
        else send_beat(rnd_ops(), 1'($urandom % 2), 1'($urandom % 2));
        if ($urandom % 12 == 0) begin
          flush_i = 1;
          idle(1);
          flush_i = 0;
        end
      end
    end
    rand_rdy = 0;
    idle(1);
    out_ready_i = 1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || out_valid_o); i++) idle(1);
    idle(2);
    chk(exp_q.size() == 0 && !busy_o, "drain",
        $sformatf("pending=%0d busy=%0b, required 0 0", exp_q.size(), busy_o));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
